wb_stage_queued: RTL and testbench

WB_STAGE_QUEUED -- requirements
Module: wb_stage_queued

---
 rtl/wb_pkg.sv | 12 +
 rtl/wb_stage_queued_if.sv | 38 +++
 rtl/wb_load_align.sv | 24 ++
 rtl/wb_stage_queued.sv | 64 ++++++
 tb/tb_wb_stage_queued.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: mem_size encodings and the writeback queue entry record (dest, value)
package wb_pkg;
  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;
  localparam int WB_N = 32;
  localparam int WB_ADDR_W = 4;
  typedef struct packed {
    logic [WB_ADDR_W-1:0] dest;
    logic [WB_N-1:0]      value;
  } wb_entry_t;
endpackage

// File: rtl/wb_stage_queued_if.sv
// wb_stage_queued_if: request (in_*, alu_res, mem_*, byte_off, wb_*, flush), rf write port (rf_*), forwarding (fwd_*) and count; master drives requests, slave is the stage
interface wb_stage_queued_if #(
  parameter int N = 32,
  parameter int ADDR_W = 4,
  parameter int DEPTH = 4
);
  localparam int OFF_W = $clog2(N / 8);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  logic              in_valid;
  logic              in_ready;
  logic [N-1:0]      alu_res;
  logic [N-1:0]      mem_data;
  logic              mem_r_en;
  logic [1:0]        mem_size;
  logic              mem_signed;
  logic [OFF_W-1:0]  byte_off;
  logic [ADDR_W-1:0] wb_dest;
  logic              wb_en;
  logic              flush;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_addr;
  logic [N-1:0]      rf_data;
  logic              rf_ready;
  logic [ADDR_W-1:0] fwd_addr;
  logic              fwd_hit;
  logic [N-1:0]      fwd_data;
  logic [CNT_W-1:0]  count;
  modport master (
    output in_valid, alu_res, mem_data, mem_r_en, mem_size, mem_signed, byte_off,
           wb_dest, wb_en, flush, rf_ready, fwd_addr,
    input  in_ready, rf_we, rf_addr, rf_data, fwd_hit, fwd_data, count
  );
  modport slave (
    input  in_valid, alu_res, mem_data, mem_r_en, mem_size, mem_signed, byte_off,
           wb_dest, wb_en, flush, rf_ready, fwd_addr,
    output in_ready, rf_we, rf_addr, rf_data, fwd_hit, fwd_data, count
  );
endinterface

// File: rtl/wb_load_align.sv
// wb_load_align: combinational writeback value select; ALU result or byte/half/word load extracted at byte_off_i and zero/sign-extended
module wb_load_align import wb_pkg::*; #(
  parameter int N = 32,
  parameter int OFF_W = $clog2(N / 8)
) (
  input  logic [N-1:0]     alu_res_i,
  input  logic [N-1:0]     mem_data_i,
  input  logic             mem_r_en_i,
  input  logic [1:0]       mem_size_i,
  input  logic             mem_signed_i,
  input  logic [OFF_W-1:0] byte_off_i,
  output logic [N-1:0]     value_o
);
  logic [OFF_W-1:0] hoff;
  logic [7:0]       b;
  logic [15:0]      h;
  assign hoff = byte_off_i & ~OFF_W'(1);
  assign b = 8'(mem_data_i >> {byte_off_i, 3'b000});
  assign h = 16'(mem_data_i >> {hoff, 3'b000});
  assign value_o = !mem_r_en_i ? alu_res_i :
                   mem_size_i >= MEM_WORD ? mem_data_i :
                   mem_size_i == MEM_HALF ? {{(N-16){mem_signed_i & h[15]}}, h} :
                   {{(N-8){mem_signed_i & b[7]}}, b};
endmodule

// File: rtl/wb_stage_queued.sv
// wb_stage_queued: in-order writeback queue; accepts aligned results (bus request side), drains head to the register file (rf_*), forwards youngest queued match (fwd_*); clk, rst sync active-high
module wb_stage_queued import wb_pkg::*; #(
  parameter int N = WB_N,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst,
  wb_stage_queued_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  wb_entry_t        q_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [N-1:0]     value;
  logic             pop, push;
  wb_load_align #(.N(N)) u_align (
    .alu_res_i(bus.alu_res),
    .mem_data_i(bus.mem_data),
    .mem_r_en_i(bus.mem_r_en),
    .mem_size_i(bus.mem_size),
    .mem_signed_i(bus.mem_signed),
    .byte_off_i(bus.byte_off),
    .value_o(value)
  );
  assign bus.rf_we = count_q != '0;
  assign bus.rf_addr = bus.rf_we ? q_q[head_q].dest : '0;
  assign bus.rf_data = bus.rf_we ? q_q[head_q].value : '0;
  assign bus.count = count_q;
  assign pop = bus.rf_we & bus.rf_ready;
  assign bus.in_ready = !rst & !bus.flush & (count_q < CNT_W'(DEPTH) | pop);
  assign push = bus.in_valid & bus.in_ready & bus.wb_en;
  always_comb begin
    head_d = bus.flush ? '0 : head_q + PTR_W'(pop);
    tail_d = bus.flush ? '0 : tail_q + PTR_W'(push);
    count_d = bus.flush ? '0 : count_q + CNT_W'(push) - CNT_W'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) q_q[tail_q] <= '{dest: bus.wb_dest, value: value};
  end
  // walk oldest to youngest so the last match seen is the youngest
  always_comb begin
    bus.fwd_hit = 1'b0;
    bus.fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < count_q && q_q[head_q + PTR_W'(i)].dest == bus.fwd_addr) begin
        bus.fwd_hit = 1'b1;
        bus.fwd_data = q_q[head_q + PTR_W'(i)].value;
      end
    end
  end
endmodule

// File: tb/tb_wb_stage_queued.sv
// tb_wb_stage_queued: directed self-checking bench for wb_stage_queued (DEPTH=4, N=32)
module tb_wb_stage_queued;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_checks = 0;
  int n_fail = 0;
  wb_stage_queued_if bus();
  wb_stage_queued dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  task automatic set_req(input logic v, input logic en, input logic mr, input logic [1:0] sz,
                         input logic sg, input logic [1:0] off, input logic [3:0] dest,
                         input logic [31:0] alu, input logic [31:0] mem);
    bus.in_valid = v; bus.wb_en = en; bus.mem_r_en = mr; bus.mem_size = sz;
    bus.mem_signed = sg; bus.byte_off = off; bus.wb_dest = dest;
    bus.alu_res = alu; bus.mem_data = mem;
  endtask
  task automatic test_reset();
    set_req(0, 0, 0, 2'b00, 0, 2'd0, 4'd0, 32'd0, 32'd0);
    bus.flush = 0; bus.rf_ready = 0; bus.fwd_addr = 4'd0;
    rst = 1;
    @(negedge clk); @(negedge clk); #1;
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got %b exp 0", bus.in_ready); end
    n_checks++; if (bus.count !== 3'd0) begin n_fail++; $display("FAIL rst_count got %0d exp 0", bus.count); end
    n_checks++; if (bus.rf_we !== 1'b0 || bus.rf_addr !== 4'd0 || bus.rf_data !== 32'd0) begin n_fail++; $display("FAIL rst_rf got we=%b a=%h d=%h exp 0", bus.rf_we, bus.rf_addr, bus.rf_data); end
    n_checks++; if (bus.fwd_hit !== 1'b0 || bus.fwd_data !== 32'd0) begin n_fail++; $display("FAIL rst_fwd got %b %h exp 0 0", bus.fwd_hit, bus.fwd_data); end
    @(negedge clk); rst = 0; #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_in_ready got %b exp 1", bus.in_ready); end
  endtask
  task automatic test_load_align();
    logic        mr [9] = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
    logic [1:0]  sz [9] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
    logic        sg [9] = '{1, 0, 1, 0, 1, 1, 1, 0, 1};
    logic [1:0]  off [9] = '{2'd3, 2'd3, 2'd3, 2'd0, 2'd2, 2'd1, 2'd1, 2'd2, 2'd3};
    logic [31:0] mem [9] = '{32'h80FF7F01, 32'h80FF7F01, 32'h8001ABCD, 32'h8001ABCD, 32'h80FF7F01,
                             32'h0000ABCD, 32'h80FF7F01, 32'h12345678, 32'h80FF7F01};
    logic [31:0] exp [9] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h0000ABCD, 32'hFFFFFFFF,
                             32'hFFFFABCD, 32'h80FF7F01, 32'h12345678, 32'hCAFEF00D};
    bus.rf_ready = 1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      set_req(1, 1, mr[i], sz[i], sg[i], off[i], 4'(i + 1), 32'hCAFEF00D, mem[i]);
      @(negedge clk);
      set_req(0, 1, mr[i], sz[i], sg[i], 2'd0, 4'd0, 32'd0, 32'd0);
      #1;
      n_checks++; if (bus.rf_we !== 1'b1 || bus.rf_addr !== 4'(i + 1) || bus.rf_data !== exp[i]) begin
        n_fail++; $display("FAIL align_%0d got we=%b a=%h d=%h exp we=1 a=%h d=%h", i, bus.rf_we, bus.rf_addr, bus.rf_data, 4'(i + 1), exp[i]);
      end
    end
    @(negedge clk); #1;
    n_checks++; if (bus.count !== 3'd0 || bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL align_drained got count=%0d we=%b exp 0 0", bus.count, bus.rf_we); end
  endtask
  task automatic test_full_drain();
    logic [3:0] order [3] = '{4'd3, 4'd4, 4'd6};
    bus.rf_ready = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      set_req(1, 1, 0, 2'b10, 0, 2'd0, 4'(k), 32'h100 + 32'(k), 32'd0);
      #1;
      n_checks++; if (bus.in_ready !== (k <= 4)) begin n_fail++; $display("FAIL full_in_ready_%0d got %b exp %b", k, bus.in_ready, k <= 4); end
    end
    @(negedge clk); bus.in_valid = 0; #1;
    n_checks++; if (bus.count !== 3'd4 || bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL full_state got count=%0d rdy=%b exp 4 0", bus.count, bus.in_ready); end
    n_checks++; if (bus.rf_addr !== 4'd1 || bus.rf_data !== 32'h101) begin n_fail++; $display("FAIL full_head got a=%h d=%h exp 1 101", bus.rf_addr, bus.rf_data); end
    bus.rf_ready = 1;
    set_req(1, 1, 0, 2'b10, 0, 2'd0, 4'd6, 32'h106, 32'd0);
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL full_push_pop_ready got %b exp 1", bus.in_ready); end
    @(negedge clk); bus.in_valid = 0; #1;
    n_checks++; if (bus.count !== 3'd4 || bus.rf_addr !== 4'd2 || bus.rf_data !== 32'h102) begin n_fail++; $display("FAIL full_after_push_pop got count=%0d a=%h d=%h exp 4 2 102", bus.count, bus.rf_addr, bus.rf_data); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      n_checks++; if (bus.rf_we !== 1'b1 || bus.rf_addr !== order[i] || bus.rf_data !== 32'h100 + 32'(order[i])) begin
        n_fail++; $display("FAIL drain_%0d got we=%b a=%h d=%h exp 1 %h %h", i, bus.rf_we, bus.rf_addr, bus.rf_data, order[i], 32'h100 + 32'(order[i]));
      end
    end
    @(negedge clk); #1;
    n_checks++; if (bus.count !== 3'd0 || bus.rf_we !== 1'b0 || bus.rf_data !== 32'd0) begin n_fail++; $display("FAIL drain_empty got count=%0d we=%b d=%h exp 0 0 0", bus.count, bus.rf_we, bus.rf_data); end
  endtask
  task automatic test_forward_flush();
    bus.rf_ready = 0;
    @(negedge clk); set_req(1, 1, 0, 2'b10, 0, 2'd0, 4'd3, 32'h11, 32'd0);
    @(negedge clk); set_req(1, 1, 0, 2'b10, 0, 2'd0, 4'd3, 32'h22, 32'd0);
    @(negedge clk); set_req(1, 1, 0, 2'b10, 0, 2'd0, 4'd7, 32'h33, 32'd0);
    @(negedge clk); set_req(1, 0, 0, 2'b10, 0, 2'd0, 4'd9, 32'h99, 32'd0);
    bus.fwd_addr = 4'd9; #1;
    n_checks++; if (bus.fwd_hit !== 1'b0 || bus.fwd_data !== 32'd0) begin n_fail++; $display("FAIL fwd_incoming got %b %h exp 0 0", bus.fwd_hit, bus.fwd_data); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL wben0_ready got %b exp 1", bus.in_ready); end
    bus.fwd_addr = 4'd3; #1;
    n_checks++; if (bus.fwd_hit !== 1'b1 || bus.fwd_data !== 32'h22) begin n_fail++; $display("FAIL fwd_youngest got %b %h exp 1 22", bus.fwd_hit, bus.fwd_data); end
    bus.fwd_addr = 4'd5; #1;
    n_checks++; if (bus.fwd_hit !== 1'b0 || bus.fwd_data !== 32'd0) begin n_fail++; $display("FAIL fwd_miss got %b %h exp 0 0", bus.fwd_hit, bus.fwd_data); end
    bus.fwd_addr = 4'd7; #1;
    n_checks++; if (bus.fwd_hit !== 1'b1 || bus.fwd_data !== 32'h33) begin n_fail++; $display("FAIL fwd_r7 got %b %h exp 1 33", bus.fwd_hit, bus.fwd_data); end
    @(negedge clk); #1;
    n_checks++; if (bus.count !== 3'd3) begin n_fail++; $display("FAIL wben0_count got %0d exp 3", bus.count); end
    bus.flush = 1;
    set_req(1, 1, 0, 2'b10, 0, 2'd0, 4'd4, 32'h44, 32'd0);
    #1;
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready got %b exp 0", bus.in_ready); end
    @(negedge clk); bus.flush = 0; bus.in_valid = 0; bus.fwd_addr = 4'd3; #1;
    n_checks++; if (bus.count !== 3'd0 || bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL flush_state got count=%0d we=%b exp 0 0", bus.count, bus.rf_we); end
    n_checks++; if (bus.fwd_hit !== 1'b0 || bus.fwd_data !== 32'd0) begin n_fail++; $display("FAIL flush_fwd got %b %h exp 0 0", bus.fwd_hit, bus.fwd_data); end
    @(negedge clk); set_req(1, 0, 0, 2'b10, 0, 2'd0, 4'd2, 32'h55, 32'd0);
    @(negedge clk); bus.in_valid = 0; #1;
    n_checks++; if (bus.count !== 3'd0 || bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL wben0_empty got count=%0d we=%b exp 0 0", bus.count, bus.rf_we); end
  endtask
  task automatic test_back_to_back();
    bus.rf_ready = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      set_req(1, 1, 0, 2'b10, 0, 2'd0, 4'(k), 32'hA00 + 32'(k), 32'd0);
      #1;
      if (k > 0) begin
        n_checks++; if (bus.count !== 3'd1 || bus.rf_addr !== 4'(k - 1) || bus.rf_data !== 32'hA00 + 32'(k - 1)) begin
          n_fail++; $display("FAIL stream_%0d got count=%0d a=%h d=%h exp 1 %h %h", k, bus.count, bus.rf_addr, bus.rf_data, 4'(k - 1), 32'hA00 + 32'(k - 1));
        end
      end
    end
    @(negedge clk); bus.in_valid = 0; #1;
    n_checks++; if (bus.rf_data !== 32'hA09) begin n_fail++; $display("FAIL stream_last got %h exp a09", bus.rf_data); end
    @(negedge clk); #1;
    n_checks++; if (bus.count !== 3'd0) begin n_fail++; $display("FAIL stream_empty got %0d exp 0", bus.count); end
  endtask
  task automatic test_reset_mid();
    bus.rf_ready = 0;
    @(negedge clk); set_req(1, 1, 0, 2'b10, 0, 2'd0, 4'd5, 32'h55, 32'd0);
    @(negedge clk); set_req(1, 1, 0, 2'b10, 0, 2'd0, 4'd6, 32'h66, 32'd0);
    @(negedge clk); bus.in_valid = 0; bus.rf_ready = 1; bus.fwd_addr = 4'd5; rst = 1; #1;
    n_checks++; if (bus.count !== 3'd2 || bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_pre got count=%0d rdy=%b exp 2 0", bus.count, bus.in_ready); end
    @(negedge clk); rst = 0; #1;
    n_checks++; if (bus.rf_we !== 1'b0 || bus.rf_addr !== 4'd0 || bus.rf_data !== 32'd0 || bus.count !== 3'd0) begin
      n_fail++; $display("FAIL rstmid_rf got we=%b a=%h d=%h count=%0d exp 0", bus.rf_we, bus.rf_addr, bus.rf_data, bus.count);
    end
    n_checks++; if (bus.fwd_hit !== 1'b0 || bus.fwd_data !== 32'd0) begin n_fail++; $display("FAIL rstmid_fwd got %b %h exp 0 0", bus.fwd_hit, bus.fwd_data); end
    @(negedge clk); #1;
    n_checks++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL rstmid_quiet got %b exp 0", bus.rf_we); end
  endtask
  initial begin
    test_reset();
    test_load_align();
    test_full_drain();
    test_forward_flush();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
